// File: rtl/gfx_bus_master.sv
// gfx_bus_master
// ---------------------------------------------------------------------------
// Bus master for a 6502-style peripheral adapter. It generates a free-running
// phi2 bus clock from the system clock, queues register read/write commands
// in a small FIFO and replays them onto the adapter bus, one command per phi2
// period.
//
// Bus cycle, with cnt counting 0 .. 2*HALF_CYC-1:
//   cnt 0 .. HALF_CYC-1        phi2 low
//   cnt HALF_CYC .. 2*HC-1     phi2 high
//   cnt 2                      chip selected, address/strobe/write data driven
//   cnt 2*HC-1                 read data sampled from the bus
//   cnt 1 (next period)        chip deselected, rd_valid pulses for reads
//
// Ports:
//   clk, rst                   system clock, asynchronous active-high reset
//   cmd_valid/cmd_ready        command push handshake (ready = FIFO not full)
//   cmd_rnw, cmd_addr, cmd_data  command contents (1 = read)
//   rd_valid, rd_data          one-cycle read-back strobe and byte
//   busy                       queued work or bus transaction in progress
//   phi2_o                     bus clock to the adapter
//   cs_o, rs_o, wren_o         chip select (low), register select, write
//                              enable (low = write)
//   data_o, data_oe_o, data_i  split bidirectional data bus
// ---------------------------------------------------------------------------
module gfx_bus_master #(
  parameter int unsigned HALF_CYC   = 25,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rnw,
  input  logic [3:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       phi2_o,
  output logic       cs_o,
  output logic [3:0] rs_o,
  output logic       wren_o,
  output logic [7:0] data_o,
  output logic       data_oe_o,
  input  logic [7:0] data_i
);

  localparam int unsigned CNT_W  = $clog2(2 * HALF_CYC);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned FILL_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(2 * HALF_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(HALF_CYC);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_TWO  = CNT_W'(2);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(FIFO_DEPTH);

  typedef struct packed {
    logic       rnw;
    logic [3:0] addr;
    logic [7:0] data;
  } cmd_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // ---------------------------------------------------------------------
  // Phase counter
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_ONE;
  end

  // ---------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------
  cmd_t              fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [FILL_W-1:0] fill_q;
  logic              push, pop;
  cmd_t              head;
  state_t            state_q;

  assign cmd_ready = (fill_q != FILL_MAX);
  assign push      = cmd_valid && cmd_ready;
  assign head      = fifo_mem[rd_ptr_q];

  // All bus outputs are registered and computed from the next count, so they
  // change together with cnt. The start decision therefore uses the
  // registered fill level during the cycle before cnt==2; a command pushed
  // any later waits a full period.
  assign pop = (state_q == ST_IDLE) && (cnt_d == CNT_TWO) && (fill_q != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= cmd_t'{rnw: cmd_rnw, addr: cmd_addr, data: cmd_data};
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop)      fill_q <= fill_q + FILL_W'(1);
      else if (pop && !push) fill_q <= fill_q - FILL_W'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Bus sequencer with registered outputs
  // ---------------------------------------------------------------------
  logic       phi2_q;
  logic       cs_q;
  logic [3:0] rs_q;
  logic       wren_q;
  logic [7:0] data_out_q;
  logic       data_oe_q;
  logic       rd_valid_q;
  logic [7:0] rd_data_q;
  logic       rd_act_q;   // current transaction is a read

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      phi2_q     <= 1'b0;
      cs_q       <= 1'b1;
      rs_q       <= 4'h0;
      wren_q     <= 1'b1;
      data_out_q <= 8'h00;
      data_oe_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'h00;
      rd_act_q   <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      phi2_q     <= (cnt_d >= CNT_HALF);
      rd_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            state_q  <= ST_ACTIVE;
            cs_q     <= 1'b0;
            rs_q     <= head.addr;
            wren_q   <= head.rnw;
            rd_act_q <= head.rnw;
            if (!head.rnw) begin
              data_out_q <= head.data;
              data_oe_q  <= 1'b1;
            end
          end
        end
        ST_ACTIVE: begin
          // Capture the byte the adapter presents in the last high cycle.
          if (rd_act_q && (cnt_q == CNT_MAX)) begin
            rd_data_q <= data_i;
          end
          // Keep the chip selected through cnt==0 so the adapter sees the
          // phi2 fall with valid strobes; release it at cnt==1.
          if (cnt_d == CNT_ONE) begin
            state_q    <= ST_IDLE;
            cs_q       <= 1'b1;
            wren_q     <= 1'b1;
            data_oe_q  <= 1'b0;
            rd_valid_q <= rd_act_q;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign phi2_o    = phi2_q;
  assign cs_o      = cs_q;
  assign rs_o      = rs_q;
  assign wren_o    = wren_q;
  assign data_o    = data_out_q;
  assign data_oe_o = data_oe_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign busy      = (fill_q != '0) || (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_gfx_bus_master.sv
// tb_gfx_bus_master
// Directed bench for gfx_bus_master with HALF_CYC=4, FIFO_DEPTH=4.
// The bench keeps its own phase counter (tb_cnt) reset alongside the DUT and
// samples all outputs on the falling clock edge.
module tb_gfx_bus_master;

  localparam int HC = 4;
  localparam int FD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_rnw = 1'b0;
  logic [3:0] cmd_addr = 4'h0;
  logic [7:0] cmd_data = 8'h00;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       busy;
  logic       phi2_o;
  logic       cs_o;
  logic [3:0] rs_o;
  logic       wren_o;
  logic [7:0] data_o;
  logic       data_oe_o;
  logic [7:0] data_i = 8'hEE;

  int checks = 0;
  int errors = 0;
  int tb_cnt = 0;

  gfx_bus_master #(.HALF_CYC(HC), .FIFO_DEPTH(FD)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_rnw   (cmd_rnw),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .busy      (busy),
    .phi2_o    (phi2_o),
    .cs_o      (cs_o),
    .rs_o      (rs_o),
    .wren_o    (wren_o),
    .data_o    (data_o),
    .data_oe_o (data_oe_o),
    .data_i    (data_i)
  );

  always #5 clk = ~clk;

  // Reference phase counter: 0 .. 2*HC-1, cleared by reset.
  always @(posedge clk or posedge rst) begin
    if (rst) tb_cnt <= 0;
    else     tb_cnt <= (tb_cnt == 2 * HC - 1) ? 0 : tb_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t cnt=%0d)", tag, obs, exp, $time, tb_cnt);
    end
  endtask

  task automatic wait_cnt(input int n);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (tb_cnt != n && k < 4 * HC);
    if (tb_cnt != n) check("wait_cnt", tb_cnt, n);
  endtask

  // Checks one complete bus transaction. Entered at the sample of cnt==2,
  // leaves at the sample of cnt==1 of the following period.
  task automatic observe_txn(input string name, input logic rnw, input logic [3:0] addr,
                             input logic [7:0] wdata, input logic [7:0] rbyte,
                             input logic busy_end);
    for (int s = 0; s < 7; s++) begin
      if (s > 0) @(negedge clk);
      if (tb_cnt == HC) data_i = rbyte;
      check({name, ":cs"},   cs_o, 0);
      check({name, ":rs"},   rs_o, addr);
      check({name, ":wren"}, wren_o, rnw);
      check({name, ":oe"},   data_oe_o, !rnw);
      if (!rnw) check({name, ":data_o"}, data_o, wdata);
      check({name, ":rdv"},  rd_valid, 0);
      check({name, ":busy"}, busy, 1);
      check({name, ":phi2"}, phi2_o, tb_cnt >= HC);
    end
    @(negedge clk);
    data_i = 8'hEE;
    check({name, ":end_cs"},   cs_o, 1);
    check({name, ":end_wren"}, wren_o, 1);
    check({name, ":end_oe"},   data_oe_o, 0);
    check({name, ":end_rs"},   rs_o, addr);
    check({name, ":end_rdv"},  rd_valid, rnw);
    check({name, ":end_busy"}, busy, busy_end);
    if (rnw) check({name, ":rd_data"}, rd_data, rbyte);
    $display("TXN %s rnw=%0d addr=%0h wdata=%02h rd_data=%02h", name, rnw, addr, wdata, rd_data);
  endtask

  task automatic drive_cmd(input logic v, input logic rnw, input logic [3:0] a, input logic [7:0] d);
    cmd_valid = v;
    cmd_rnw   = rnw;
    cmd_addr  = a;
    cmd_data  = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    check("rst:cs", cs_o, 1);
    check("rst:wren", wren_o, 1);
    check("rst:rs", rs_o, 0);
    check("rst:data_o", data_o, 0);
    check("rst:oe", data_oe_o, 0);
    check("rst:rdv", rd_valid, 0);
    check("rst:rd_data", rd_data, 0);
    check("rst:ready", cmd_ready, 1);
    check("rst:busy", busy, 0);
    check("rst:phi2", phi2_o, 0);
    rst = 1'b0;
    $display("TXN reset released");

    // ---------------- free run, 10 periods ----------------
    for (int i = 0; i < 10 * 2 * HC; i++) begin
      @(negedge clk);
      check("free:phi2", phi2_o, tb_cnt >= HC);
      check("free:cs", cs_o, 1);
    end
    $display("TXN free run 10 periods");

    // ---------------- single write ----------------
    wait_cnt(4);
    drive_cmd(1, 0, 4'h1, 8'h41);
    @(negedge clk);
    drive_cmd(0, 0, 4'h0, 8'h00);
    check("wr:busy_queued", busy, 1);
    wait_cnt(2);
    observe_txn("wr41", 0, 4'h1, 8'h41, 8'h00, 0);

    // ---------------- single read ----------------
    wait_cnt(5);
    drive_cmd(1, 1, 4'h3, 8'hFF);
    @(negedge clk);
    drive_cmd(0, 0, 4'h0, 8'h00);
    wait_cnt(2);
    observe_txn("rd3", 1, 4'h3, 8'h00, 8'h5A, 0);
    @(negedge clk);
    check("rd:single_pulse", rd_valid, 0);
    check("rd:hold", rd_data, 8'h5A);

    // ---------------- five pushes, fifth dropped ----------------
    wait_cnt(3);
    for (int i = 0; i < 5; i++) begin
      check("fill:ready", cmd_ready, i < FD);
      drive_cmd(1, 0, 4'(4 + i), 8'(8'hA0 + i));
      @(negedge clk);
    end
    drive_cmd(0, 0, 4'h0, 8'h00);
    check("fill:full", cmd_ready, 0);
    wait_cnt(2);
    check("fill:ready_after_pop", cmd_ready, 1);
    for (int i = 0; i < FD; i++) begin
      if (i > 0) @(negedge clk);
      observe_txn("b2b", 0, 4'(4 + i), 8'(8'hA0 + i), 8'h00, i != FD - 1);
    end
    for (int i = 0; i < 2 * HC; i++) begin
      @(negedge clk);
      check("b2b:no_fifth_cs", cs_o, 1);
      check("b2b:no_fifth_busy", busy, 0);
    end

    // ---------------- late push at cnt==3 ----------------
    wait_cnt(3);
    drive_cmd(1, 0, 4'hF, 8'hC3);
    @(negedge clk);
    drive_cmd(0, 0, 4'h0, 8'h00);
    while (tb_cnt != 2) begin
      check("late:cs_idle", cs_o, 1);
      @(negedge clk);
    end
    observe_txn("late", 0, 4'hF, 8'hC3, 8'h00, 0);

    // ---------------- reset during ACTIVE ----------------
    wait_cnt(3);
    for (int i = 0; i < 3; i++) begin
      drive_cmd(1, 0, 4'(5 + i), 8'(8'h55 + 8'h11 * i));
      @(negedge clk);
    end
    drive_cmd(0, 0, 4'h0, 8'h00);
    wait_cnt(2);
    check("abort:active_cs", cs_o, 0);
    wait_cnt(6);
    check("abort:pre_phi2", phi2_o, 1);
    check("abort:pre_oe", data_oe_o, 1);
    rst = 1'b1;
    #1;
    check("abort:cs", cs_o, 1);
    check("abort:oe", data_oe_o, 0);
    check("abort:phi2", phi2_o, 0);
    check("abort:busy", busy, 0);
    check("abort:rdv", rd_valid, 0);
    check("abort:ready", cmd_ready, 1);
    $display("TXN reset during active write");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3 * 2 * HC; i++) begin
      @(negedge clk);
      check("abort:quiet_cs", cs_o, 1);
      check("abort:quiet_busy", busy, 0);
      check("abort:quiet_rdv", rd_valid, 0);
      check("abort:phi2_run", phi2_o, tb_cnt >= HC);
    end

    // ---------------- new push after abort ----------------
    drive_cmd(1, 1, 4'h9, 8'h00);
    @(negedge clk);
    drive_cmd(0, 0, 4'h0, 8'h00);
    wait_cnt(2);
    observe_txn("post_rst", 1, 4'h9, 8'h00, 8'h3C, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
